mdu_iter: RTL and testbench

//  Parametrised iterative multiply/divide unit with architectural HI/LO, sitting in EX beside the ALU.

---
 rtl/mdu_pkg.sv | 49 ++++
 rtl/mdu_iter_step.sv | 47 ++++
 rtl/mdu_iter.sv | 167 ++++++++++++++++
 tb/tb_mdu_iter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared op encoding, FSM state type and decode helpers for the iterative MDU.
package mdu_pkg;

    localparam int MDU_OP_W = 4;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MADD  = 4'd5,
        MDU_MADDU = 4'd6,
        MDU_MSUB  = 4'd7,
        MDU_MSUBU = 4'd8,
        MDU_MTHI  = 4'd9,
        MDU_MTLO  = 4'd10,
        MDU_MFHI  = 4'd11,
        MDU_MFLO  = 4'd12
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_t;

    function automatic logic is_arith(input mdu_op_t op);
        return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU,
                          MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
    endfunction

    function automatic logic is_div(input mdu_op_t op);
        return op inside {MDU_DIV, MDU_DIVU};
    endfunction

    function automatic logic is_signed_op(input mdu_op_t op);
        return op inside {MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB};
    endfunction

    function automatic logic is_madd(input mdu_op_t op);
        return op inside {MDU_MADD, MDU_MADDU};
    endfunction

    function automatic logic is_msub(input mdu_op_t op);
        return op inside {MDU_MSUB, MDU_MSUBU};
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the MDU datapath: BITS_PER_CYCLE shift-add (multiply) or
// restoring trial-subtract (divide) steps on the {hi,lo} partial register pair.
module mdu_iter_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opd_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] hi_v;
    logic [WIDTH-1:0] lo_v;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        hi_v   = hi_i;
        lo_v   = lo_i;
        sum    = '0;
        rem_sh = '0;
        diff   = '0;
        ge     = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (is_div_i) begin
                // Remainder stays below the divisor, so the difference fits WIDTH bits.
                rem_sh = {hi_v, lo_v[WIDTH-1]};
                ge     = (rem_sh >= {1'b0, opd_i});
                diff   = rem_sh[WIDTH-1:0] - opd_i;
                hi_v   = ge ? diff : rem_sh[WIDTH-1:0];
                lo_v   = {lo_v[WIDTH-2:0], ge};
            end else begin
                sum  = {1'b0, hi_v} + (lo_v[0] ? {1'b0, opd_i} : {(WIDTH+1){1'b0}});
                lo_v = {sum[0], lo_v[WIDTH-1:1]};
                hi_v = sum[WIDTH:1];
            end
        end
        hi_o = hi_v;
        lo_o = lo_v;
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO: busy for WIDTH/BITS_PER_CYCLE+1 cycles
// after issue; ops presented while busy are ignored (decode is stalled on busy).
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             int_exc_req,
    input  mdu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    mdu_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    mdu_op_t          op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] part_hi_q, part_hi_d;
    logic [WIDTH-1:0] part_lo_q, part_lo_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             div0_q, div0_d;

    logic             sgn_a, sgn_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic             div_op;
    logic [2*WIDTH-1:0] prod_mag, prod_sgn, hilo_cur;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign sgn_a = is_signed_op(op) & a[WIDTH-1];
    assign sgn_b = is_signed_op(op) & b[WIDTH-1];
    assign mag_a = sgn_a ? -a : a;
    assign mag_b = sgn_b ? -b : b;
    assign div_op = is_div(op_q);

    // Signs are stripped at issue and re-applied here in FIX.
    assign prod_mag = {part_hi_q, part_lo_q};
    assign prod_sgn = neg_q ? -prod_mag : prod_mag;
    assign hilo_cur = {hi_q, lo_q};
    assign quo_fix  = div0_q ? {WIDTH{1'b1}} : (neg_q ? -part_lo_q : part_lo_q);
    assign rem_fix  = rneg_q ? -part_hi_q : part_hi_q;

    mdu_iter_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .is_div_i (div_op),
        .hi_i     (part_hi_q),
        .lo_i     (part_lo_q),
        .opd_i    (opd_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        part_hi_d = part_hi_q;
        part_lo_d = part_lo_q;
        opd_d     = opd_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        div0_d    = div0_q;
        case (state_q)
            ST_IDLE: begin
                if (!int_exc_req) begin
                    if (is_arith(op)) begin
                        state_d   = ST_RUN;
                        cnt_d     = '0;
                        op_d      = op;
                        neg_d     = sgn_a ^ sgn_b;
                        rneg_d    = sgn_a;
                        div0_d    = (b == '0);
                        part_hi_d = '0;
                        // Divide shifts the dividend through lo; multiply shifts the multiplier.
                        if (is_div(op)) begin
                            part_lo_d = mag_a;
                            opd_d     = mag_b;
                        end else begin
                            part_lo_d = mag_b;
                            opd_d     = mag_a;
                        end
                    end else if (op == MDU_MTHI) begin
                        hi_d = a;
                    end else if (op == MDU_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_RUN: begin
                part_hi_d = step_hi;
                part_lo_d = step_lo;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (is_div(op_q)) begin
                    {hi_d, lo_d} = {rem_fix, quo_fix};
                end else if (is_madd(op_q)) begin
                    {hi_d, lo_d} = hilo_cur + prod_sgn;
                end else if (is_msub(op_q)) begin
                    {hi_d, lo_d} = hilo_cur - prod_sgn;
                end else begin
                    {hi_d, lo_d} = prod_sgn;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= MDU_NONE;
            hi_q      <= '0;
            lo_q      <= '0;
            part_hi_q <= '0;
            part_lo_q <= '0;
            opd_q     <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            part_hi_q <= part_hi_d;
            part_lo_q <= part_lo_d;
            opd_q     <= opd_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            div0_q    <= div0_d;
        end
    end

    always_comb begin
        result = '0;
        if (op == MDU_MFHI) begin
            result = hi_q;
        end else if (op == MDU_MFLO) begin
            result = lo_q;
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed cases on a 32-bit/1-bit-per-cycle unit plus random
// ops on three configurations checked against an arithmetic model through a scoreboard.
module tb_mdu_iter;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_op_t     op_r  [3];
    logic [31:0] a_r   [3];
    logic [31:0] b_r   [3];
    logic        exc_r [3];
    logic [31:0] res0, res1;
    logic [15:0] res2;
    logic        bsy0, bsy1, bsy2;

    int wid [3] = '{32, 32, 16};
    int bpc [3] = '{1, 4, 2};

    logic [31:0] m_hi [3];
    logic [31:0] m_lo [3];

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    exp_t sb [$];

    int n_cmp = 0;
    int n_err = 0;

    mdu_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut0 (
        .clk(clk), .reset(reset), .int_exc_req(exc_r[0]), .op(op_r[0]),
        .a(a_r[0]), .b(b_r[0]), .result(res0), .busy(bsy0));
    mdu_iter #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut1 (
        .clk(clk), .reset(reset), .int_exc_req(exc_r[1]), .op(op_r[1]),
        .a(a_r[1]), .b(b_r[1]), .result(res1), .busy(bsy1));
    mdu_iter #(.WIDTH(16), .BITS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .reset(reset), .int_exc_req(exc_r[2]), .op(op_r[2]),
        .a(a_r[2][15:0]), .b(b_r[2][15:0]), .result(res2), .busy(bsy2));

    function automatic logic [31:0] get_res(input int k);
        case (k)
            0: return res0;
            1: return res1;
            default: return {16'h0, res2};
        endcase
    endfunction

    function automatic logic get_busy(input int k);
        case (k)
            0: return bsy0;
            1: return bsy1;
            default: return bsy2;
        endcase
    endfunction

    function automatic logic is_ar(input mdu_op_t o);
        return o inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU,
                         MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
    endfunction

    // Reference arithmetic on w-bit operands using 64-bit host integers.
    function automatic void model_op(input int k, input mdu_op_t o,
                                     input logic [31:0] av, input logic [31:0] bv);
        int          w;
        longint      one;
        logic [63:0] m, ua, ub, hilo;
        longint      sa, sbv;
        w    = wid[k];
        one  = 1;
        m    = (64'd1 << w) - 64'd1;
        ua   = {32'h0, av} & m;
        ub   = {32'h0, bv} & m;
        sa   = longint'(ua) - (ua[w-1] ? (one << w) : 64'sd0);
        sbv  = longint'(ub) - (ub[w-1] ? (one << w) : 64'sd0);
        hilo = ({32'h0, m_hi[k]} << w) | {32'h0, m_lo[k]};
        case (o)
            MDU_MULT:  hilo = $unsigned(sa * sbv);
            MDU_MULTU: hilo = ua * ub;
            MDU_MADD:  hilo = hilo + $unsigned(sa * sbv);
            MDU_MADDU: hilo = hilo + ua * ub;
            MDU_MSUB:  hilo = hilo - $unsigned(sa * sbv);
            MDU_MSUBU: hilo = hilo - ua * ub;
            MDU_DIV: begin
                if (sbv == 0) hilo = (ua << w) | m;
                else hilo = (($unsigned(sa % sbv) & m) << w) | ($unsigned(sa / sbv) & m);
            end
            MDU_DIVU: begin
                if (ub == 0) hilo = (ua << w) | m;
                else hilo = ((ua % ub) << w) | (ua / ub);
            end
            MDU_MTHI: hilo = (ua << w) | (hilo & m);
            MDU_MTLO: hilo = (hilo & ~m) | ua;
            default: ;
        endcase
        m_hi[k] = 32'((hilo >> w) & m);
        m_lo[k] = 32'(hilo & m);
    endfunction

    function automatic logic [31:0] pick(input int k);
        logic [31:0] m;
        m = (wid[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid[k]) - 32'd1);
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return m;
            3: return 32'd1 << (wid[k] - 1);
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic read_check(input int k, input string nm);
        logic [31:0] h, l;
        exp_t e;
        @(negedge clk);
        op_r[k] = MDU_MFHI;
        #1 h = get_res(k);
        op_r[k] = MDU_MFLO;
        #1 l = get_res(k);
        op_r[k] = MDU_NONE;
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s scoreboard empty at readback", nm);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (h !== e.hi) begin
                n_err++;
                $display("FAIL %s dut%0d HI got %h want %h", nm, k, h, e.hi);
            end
            n_cmp++;
            if (l !== e.lo) begin
                n_err++;
                $display("FAIL %s dut%0d LO got %h want %h", nm, k, l, e.lo);
            end
        end
    endtask

    // Present one op for one edge, measure busy, optionally read HI/LO back.
    task automatic issue(input int k, input mdu_op_t o, input logic [31:0] av,
                         input logic [31:0] bv, input logic ex, input int exc_at,
                         input bit rd, input string nm);
        int   n;
        exp_t e;
        @(negedge clk);
        op_r[k] = o; a_r[k] = av; b_r[k] = bv; exc_r[k] = ex;
        @(posedge clk);
        #1;
        op_r[k] = MDU_NONE; exc_r[k] = 1'b0; a_r[k] = $urandom; b_r[k] = $urandom;
        if (!ex) model_op(k, o, av, bv);
        if (is_ar(o) && !ex) begin
            n = 0;
            while (get_busy(k) && n < 200) begin
                exc_r[k] = (n == exc_at);
                @(posedge clk);
                #1 n++;
            end
            exc_r[k] = 1'b0;
            n_cmp++;
            if (n != wid[k] / bpc[k] + 1) begin
                n_err++;
                $display("FAIL %s dut%0d busy cycles got %0d want %0d", nm, k, n, wid[k] / bpc[k] + 1);
            end
        end else begin
            n_cmp++;
            if (get_busy(k) !== 1'b0) begin
                n_err++;
                $display("FAIL %s dut%0d busy got %b want 0", nm, k, get_busy(k));
            end
        end
        if (rd) begin
            e.hi = m_hi[k];
            e.lo = m_lo[k];
            sb.push_back(e);
            read_check(k, nm);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin m_hi[k] = '0; m_lo[k] = '0; end
        #1;
        n_cmp++;
        if ({bsy0, bsy1, bsy2} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_busy got %b want 000", {bsy0, bsy1, bsy2});
        end
        n_cmp++;
        if (res0 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_result got %h want 0", res0);
        end
        e.hi = '0; e.lo = '0;
        sb.push_back(e);
        read_check(0, "reset_hilo");
    endtask

    task automatic test_mult();
        issue(0, MDU_MULT,  32'hFFFF_FFFD, 32'd7, 1'b0, -1, 1'b1, "mult_neg");
        issue(0, MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, 1'b1, "multu_max");
    endtask

    task automatic test_back_to_back();
        issue(0, MDU_MTHI,  32'd0, 32'd0, 1'b0, -1, 1'b0, "mthi");
        issue(0, MDU_MTLO,  32'd10, 32'd0, 1'b0, -1, 1'b0, "mtlo");
        issue(0, MDU_MADDU, 32'hFFFF_FFFF, 32'd2, 1'b0, -1, 1'b1, "maddu");
        issue(0, MDU_MSUB,  32'd3, 32'd3, 1'b0, -1, 1'b0, "msub_b2b");
        issue(0, MDU_MADD,  32'hFFFF_FFFE, 32'd5, 1'b0, -1, 1'b1, "madd_b2b");
    endtask

    task automatic test_div();
        issue(0, MDU_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0, -1, 1'b1, "div_neg");
        issue(0, MDU_DIVU, 32'd5, 32'd0, 1'b0, -1, 1'b1, "divu_zero");
        issue(0, MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, 1'b1, "div_min_m1");
        issue(0, MDU_DIV,  32'hFFFF_FFF9, 32'd0, 1'b0, -1, 1'b1, "div_neg_zero");
    endtask

    task automatic test_exc();
        issue(0, MDU_MULTU, 32'd9, 32'd9, 1'b1, -1, 1'b1, "exc_multu");
        issue(0, MDU_MTLO,  32'h1234, 32'd0, 1'b1, -1, 1'b1, "exc_mtlo");
        issue(0, MDU_DIV,   32'd100, 32'hFFFF_FFF9, 1'b0, 5, 1'b1, "exc_mid_div");
    endtask

    task automatic test_reset_mid();
        exp_t e;
        issue(0, MDU_MTHI, 32'hAAAA_5555, 32'd0, 1'b0, -1, 1'b0, "pre_mthi");
        @(negedge clk);
        op_r[0] = MDU_DIVU; a_r[0] = 32'd1000; b_r[0] = 32'd7;
        @(posedge clk);
        #1 op_r[0] = MDU_NONE;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin m_hi[k] = '0; m_lo[k] = '0; end
        n_cmp++;
        if (bsy0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_busy got %b want 0", bsy0);
        end
        e.hi = '0; e.lo = '0;
        sb.push_back(e);
        read_check(0, "reset_mid_hilo");
    endtask

    task automatic test_random(input int k, input int nops);
        mdu_op_t o;
        logic    ex;
        for (int i = 0; i < nops; i++) begin
            o  = mdu_op_t'($urandom_range(1, 10));
            ex = ($urandom_range(0, 7) == 0);
            issue(k, o, pick(k), pick(k), ex, -1, 1'b1, "random");
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            op_r[k] = MDU_NONE; a_r[k] = '0; b_r[k] = '0; exc_r[k] = 1'b0;
            m_hi[k] = '0; m_lo[k] = '0;
        end
        reset = 1'b1;
        test_reset();
        test_mult();
        test_back_to_back();
        test_div();
        test_exc();
        test_reset_mid();
        test_random(0, 200);
        test_random(1, 400);
        test_random(2, 400);
        if (sb.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

endmodule
